// File: rtl/ucsbece154b_fetch_queue_pkg.sv
// Types and helpers shared by the fetch queue.
`include "ucsbece154b_defines.vh"

package ucsbece154b_fetch_queue_pkg;

   localparam logic [31:0] NOP_INSTR = `UCSBECE154B_NOP;

   typedef enum logic [1:0] {
      ENQ_NONE    = 2'b00,
      ENQ_ONE     = 2'b01,
      ENQ_ILLEGAL = 2'b10,
      ENQ_TWO     = 2'b11
   } enq_mode_e;

   // Decode never consumes more than two entries per cycle.
   function automatic logic [1:0] clamp_take(input logic [1:0] take);
      return (take == 2'd3) ? 2'd2 : take;
   endfunction

endpackage

// File: rtl/ucsbece154b_defines.vh
// Shared encodings for the ucsbece154b pipeline.
`ifndef UCSBECE154B_DEFINES_VH
`define UCSBECE154B_DEFINES_VH

`define UCSBECE154B_NOP 32'h00000013

`endif

// File: rtl/ucsbece154b_fetch_queue.sv
// Dual-entry fetch queue between fetch and decode: circular buffer,
// first-word-fall-through outputs, flush discards everything.
module ucsbece154b_fetch_queue
   import ucsbece154b_fetch_queue_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush_i,
   input  logic [1:0]                enq_valid_i,
   input  logic [31:0]               enq_instr0_i,
   input  logic [31:0]               enq_instr1_i,
   input  logic [31:0]               enq_pc0_i,
   input  logic [31:0]               enq_pc1_i,
   output logic                      enq_ready_o,
   input  logic [1:0]                deq_take_i,
   output logic                      deq_valid0_o,
   output logic                      deq_valid1_o,
   output logic [31:0]               deq_instr0_o,
   output logic [31:0]               deq_instr1_o,
   output logic [31:0]               deq_pc0_o,
   output logic [31:0]               deq_pc1_o,
   output logic [$clog2(DEPTH):0]    count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   instr_q [DEPTH];
   logic [31:0]   pc_q    [DEPTH];
   logic [AW-1:0] head, tail, head_p1, tail_p1;
   logic [CW-1:0] count;
   logic [1:0]    enq_num, take_sat, take_eff;
   enq_mode_e     mode;

   assign head_p1     = head + AW'(1);
   assign tail_p1     = tail + AW'(1);
   assign mode        = enq_mode_e'(enq_valid_i);
   // Only the registered count decides readiness, so two free slots are
   // guaranteed and an enqueue can never land on an entry being read.
   assign enq_ready_o = (count <= CW'(DEPTH - 2));

   always_comb begin
      enq_num  = 2'd0;
      take_sat = clamp_take(deq_take_i);
      take_eff = take_sat;
      if (enq_ready_o && !flush_i) begin
         case (mode)
            ENQ_ONE: enq_num = 2'd1;
            ENQ_TWO: enq_num = 2'd2;
            default: enq_num = 2'd0;
         endcase
      end
      if (CW'(take_sat) > count) take_eff = count[1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(take_eff);
         tail  <= tail + AW'(enq_num);
         count <= count + CW'(enq_num) - CW'(take_eff);
      end
   end

   always_ff @(posedge clk) begin
      if (enq_num != 2'd0) begin
         instr_q[tail] <= enq_instr0_i;
         pc_q[tail]    <= enq_pc0_i;
      end
      if (enq_num == 2'd2) begin
         instr_q[tail_p1] <= enq_instr1_i;
         pc_q[tail_p1]    <= enq_pc1_i;
      end
   end

   assign deq_valid0_o = (count != '0);
   assign deq_valid1_o = (count >= CW'(2));
   assign deq_instr0_o = deq_valid0_o ? instr_q[head]    : NOP_INSTR;
   assign deq_instr1_o = deq_valid1_o ? instr_q[head_p1] : NOP_INSTR;
   assign deq_pc0_o    = deq_valid0_o ? pc_q[head]       : 32'h0;
   assign deq_pc1_o    = deq_valid1_o ? pc_q[head_p1]    : 32'h0;
   assign count_o      = count;

endmodule

// File: tb/tb_ucsbece154b_fetch_queue.sv
// Directed bench for the fetch queue (DEPTH=8).
module tb_ucsbece154b_fetch_queue;

   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [31:0] KEY = 32'hA5A50000;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic [1:0]  enq_valid;
   logic [31:0] enq_instr0, enq_instr1, enq_pc0, enq_pc1;
   logic        enq_ready;
   logic [1:0]  deq_take;
   logic        deq_valid0, deq_valid1;
   logic [31:0] deq_instr0, deq_instr1, deq_pc0, deq_pc1;
   logic [3:0]  count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ucsbece154b_fetch_queue #(.DEPTH(8)) dut (
      .clk(clk), .reset(reset), .flush_i(flush),
      .enq_valid_i(enq_valid),
      .enq_instr0_i(enq_instr0), .enq_instr1_i(enq_instr1),
      .enq_pc0_i(enq_pc0), .enq_pc1_i(enq_pc1),
      .enq_ready_o(enq_ready), .deq_take_i(deq_take),
      .deq_valid0_o(deq_valid0), .deq_valid1_o(deq_valid1),
      .deq_instr0_o(deq_instr0), .deq_instr1_o(deq_instr1),
      .deq_pc0_o(deq_pc0), .deq_pc1_o(deq_pc1),
      .count_o(count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 1'b0; enq_valid = 2'b00; deq_take = 2'd0;
      enq_instr0 = 32'h0; enq_instr1 = 32'h0; enq_pc0 = 32'h0; enq_pc1 = 32'h0;
   endtask

   task automatic enq_pair(input logic [31:0] pc);
      enq_valid = 2'b11;
      enq_pc0 = pc;         enq_instr0 = pc ^ KEY;
      enq_pc1 = pc + 32'd4; enq_instr1 = (pc + 32'd4) ^ KEY;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b0;
      #2;
      total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if ({deq_valid0, deq_valid1} !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b exp=00", {deq_valid0, deq_valid1}); end
      total++; if (deq_instr0 !== NOP || deq_instr1 !== NOP) begin bad++; $display("FAIL reset_instr got=%h/%h exp=%h", deq_instr0, deq_instr1, NOP); end
      total++; if (deq_pc0 !== 32'h0 || deq_pc1 !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h/%h exp=0", deq_pc0, deq_pc1); end
      total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", enq_ready); end
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic test_dual_enq();
      do_reset();
      enq_valid = 2'b11;
      enq_instr0 = 32'h00500093; enq_pc0 = 32'h0;
      enq_instr1 = 32'h00600113; enq_pc1 = 32'h4;
      total++; if (deq_valid0 !== 1'b0) begin bad++; $display("FAIL no_bypass got=%b exp=0", deq_valid0); end
      tick();
      idle();
      total++; if (count !== 4'd2) begin bad++; $display("FAIL dual_count got=%0d exp=2", count); end
      total++; if ({deq_valid0, deq_valid1} !== 2'b11) begin bad++; $display("FAIL dual_valid got=%b exp=11", {deq_valid0, deq_valid1}); end
      total++; if (deq_instr0 !== 32'h00500093 || deq_pc0 !== 32'h0) begin bad++; $display("FAIL dual_slot0 got=%h@%h exp=00500093@0", deq_instr0, deq_pc0); end
      total++; if (deq_instr1 !== 32'h00600113 || deq_pc1 !== 32'h4) begin bad++; $display("FAIL dual_slot1 got=%h@%h exp=00600113@4", deq_instr1, deq_pc1); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         enq_pair(32'h200 + 32'(i * 8));
         tick();
      end
      total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_count got=%0d exp=8", count); end
      total++; if (enq_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", enq_ready); end
      enq_pair(32'h900);
      tick();
      idle();
      total++; if (count !== 4'd8) begin bad++; $display("FAIL full_drop_count got=%0d exp=8", count); end
      total++; if (deq_pc0 !== 32'h200 || deq_pc1 !== 32'h204) begin bad++; $display("FAIL full_drop_head got=%h/%h exp=200/204", deq_pc0, deq_pc1); end
   endtask

   task automatic test_ready_ignores_deq();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         enq_pair(32'h300 + 32'(i * 8));
         tick();
      end
      enq_valid = 2'b01; enq_pc0 = 32'h318; enq_instr0 = 32'h318 ^ KEY;
      tick();
      total++; if (count !== 4'd7) begin bad++; $display("FAIL seven_count got=%0d exp=7", count); end
      total++; if (enq_ready !== 1'b0) begin bad++; $display("FAIL seven_ready got=%b exp=0", enq_ready); end
      enq_pair(32'h31C);
      deq_take = 2'd2;
      tick();
      idle();
      total++; if (count !== 4'd5) begin bad++; $display("FAIL seven_deq_count got=%0d exp=5", count); end
      total++; if (deq_pc0 !== 32'h308) begin bad++; $display("FAIL seven_deq_head got=%h exp=308", deq_pc0); end
   endtask

   task automatic test_wrap();
      int cnt;
      logic [31:0] npc, epc;
      do_reset();
      cnt = 0; npc = 32'h1000; epc = 32'h1000;
      for (int c = 0; c < 20; c++) begin
         int tk, eff;
         bit en;
         tk  = (c % 2 == 0) ? 1 : 2;
         eff = (tk < cnt) ? tk : cnt;
         en  = (cnt <= 6);
         enq_pair(npc);
         deq_take = tk[1:0];
         total++; if (count !== cnt[3:0]) begin bad++; $display("FAIL wrap_count c=%0d got=%0d exp=%0d", c, count, cnt); end
         if (eff >= 1) begin
            total++; if (deq_pc0 !== epc || deq_instr0 !== (epc ^ KEY)) begin bad++; $display("FAIL wrap_pc0 c=%0d got=%h exp=%h", c, deq_pc0, epc); end
         end
         if (eff == 2) begin
            total++; if (deq_pc1 !== epc + 32'd4) begin bad++; $display("FAIL wrap_pc1 c=%0d got=%h exp=%h", c, deq_pc1, epc + 32'd4); end
         end
         tick();
         epc = epc + 32'(4 * eff);
         if (en) npc = npc + 32'd8;
         cnt = cnt + (en ? 2 : 0) - eff;
      end
      idle();
      total++; if (epc < 32'h1040) begin bad++; $display("FAIL wrap_progress got=%h exp>=1040", epc); end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         enq_pair(32'h400 + 32'(i * 8));
         tick();
      end
      idle();
      deq_take = 2'd1;
      tick();
      total++; if (count !== 4'd5) begin bad++; $display("FAIL preflush_count got=%0d exp=5", count); end
      enq_pair(32'h800);
      deq_take = 2'd2;
      flush = 1'b1;
      tick();
      idle();
      total++; if (count !== 4'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", count); end
      total++; if (deq_valid0 !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", deq_valid0); end
      total++; if (deq_instr0 !== NOP) begin bad++; $display("FAIL flush_instr got=%h exp=%h", deq_instr0, NOP); end
      enq_valid = 2'b01; enq_pc0 = 32'h500; enq_instr0 = 32'h500 ^ KEY;
      tick();
      idle();
      total++; if (count !== 4'd1 || deq_pc0 !== 32'h500) begin bad++; $display("FAIL single_enq got=%0d@%h exp=1@500", count, deq_pc0); end
      total++; if (deq_valid1 !== 1'b0 || deq_instr1 !== NOP || deq_pc1 !== 32'h0) begin bad++; $display("FAIL slot1_empty got=%b %h %h exp=0 %h 0", deq_valid1, deq_instr1, deq_pc1, NOP); end
      enq_valid = 2'b10; enq_pc0 = 32'h600; enq_pc1 = 32'h604;
      tick();
      idle();
      total++; if (count !== 4'd1) begin bad++; $display("FAIL illegal_enq got=%0d exp=1", count); end
      deq_take = 2'd3;
      tick();
      idle();
      total++; if (count !== 4'd0) begin bad++; $display("FAIL take_clamp got=%0d exp=0", count); end
   endtask

   task automatic test_async_reset();
      do_reset();
      enq_pair(32'h700);
      tick();
      tick();
      idle();
      total++; if (count !== 4'd4) begin bad++; $display("FAIL prereset_count got=%0d exp=4", count); end
      #2;
      reset = 1'b0;
      #1;
      total++; if (count !== 4'd0 || deq_valid0 !== 1'b0) begin bad++; $display("FAIL async_reset got=%0d/%b exp=0/0", count, deq_valid0); end
      tick();
      reset = 1'b1;
      tick();
   endtask

   initial begin
      idle();
      reset = 1'b0;
      test_reset();
      test_dual_enq();
      test_fill();
      test_ready_ignores_deq();
      test_wrap();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ucsbece154b_fetch_queue.md
UCSBECE154B_FETCH_QUEUE -- requirements
Module: ucsbece154b_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 8, meaning number of instruction entries; SHALL be a power of two and at least 4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 flush_i  input  1  mispredict flush from execute (either slot); discards all entries.
REQ-005 enq_valid_i  input  2  bit0 = fetch slot 0 valid, bit1 = fetch slot 1 valid.
REQ-006 enq_instr0_i / enq_instr1_i  input  32 each  fetched instructions, program order 0 then 1.
REQ-007 enq_pc0_i / enq_pc1_i  input  32 each  PCs of the fetched instructions.
REQ-008 enq_ready_o  output  1  queue can accept two entries this cycle.
REQ-009 deq_take_i  input  2  number of entries decode consumes this cycle: 0 on stall, 1 when slot 2 not issued, 2 on dual issue.
REQ-010 deq_valid0_o / deq_valid1_o  output  1 each  head / head+1 entry present.
REQ-011 deq_instr0_o / deq_instr1_o  output  32 each  instruction at head / head+1.
REQ-012 deq_pc0_o / deq_pc1_o  output  32 each  PC at head / head+1.
REQ-013 count_o  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-014 The queue SHALL be a circular buffer with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter.
REQ-015 enq_ready_o SHALL be 1 iff (DEPTH - count) >= 2, computed from the registered count only, ignoring any same-cycle dequeue.
REQ-016 When enq_ready_o=1, enq_valid_i=2'b01 SHALL write instr0/pc0 at tail and advance tail by 1. enq_valid_i=2'b11 SHALL write instr0 at tail and instr1 at tail+1, and advance tail by 2.
REQ-017 enq_valid_i=2'b10 is illegal and SHALL be treated as no enqueue. Any enqueue while enq_ready_o=0 SHALL be dropped with no state change.
REQ-018 Outputs SHALL be first-word-fall-through and combinational from storage.
  - deq_valid0_o = (count >= 1); deq_valid1_o = (count >= 2).
REQ-019 When a deq_validN_o is 0, the matching deq_instrN_o SHALL be 32'h00000013 (addi x0,x0,0) and deq_pcN_o SHALL be 32'h0.
REQ-020 Effective take SHALL be min(deq_take_i, count, 2); deq_take_i=3 is treated as 2. Head SHALL advance by the effective take.
REQ-021 Next count SHALL be count + enqueued - effective take, with enqueue and dequeue in the same cycle both applied. Enqueue SHALL never overwrite an entry being read that cycle.
REQ-022 flush_i=1 SHALL take priority over enqueue and dequeue in the same cycle.
  - The next cycle has count=0 and head=tail.
  - The same-cycle enqueue is discarded.
REQ-023 Latency: an entry written at clock edge N SHALL appear on the deq outputs after edge N when it is at head or head+1; zero-cycle bypass from enq inputs to deq outputs is not provided.
REQ-024 Ordering SHALL be strict program order: slot 0 is always older than slot 1, across wrap-around.

Reset
REQ-025 While reset=0 (asynchronously):
  - head=0, tail=0, count_o=0.
  - deq_valid0_o=0, deq_valid1_o=0.
  - deq_instr outputs = NOP, deq_pc outputs = 0, enq_ready_o=1.
REQ-026 Storage contents need not be reset. Reset asserted mid-operation SHALL discard all entries identically to a flush.

Structure
REQ-027 The NOP encoding (32'h00000013) SHALL be added to ucsbece154b_defines.vh and used from there.
REQ-028 No sub-module; storage is a register array within ucsbece154b_fetch_queue.

Verification (DEPTH=8)
REQ-029 Reset, then enq 2'b11 with instr 0x00500093 @pc 0x0 and 0x00600113 @pc 0x4, deq_take=0 -> next cycle count_o=2, both valids 1, outputs in order.
REQ-030 Fill with four 2'b11 enqueues, deq_take=0 -> count_o=8, enq_ready_o=0; a further enqueue is dropped and count_o stays 8.
REQ-031 count=7, enq 2'b11 with deq_take=2 same cycle -> enq_ready_o=0, so the enqueue is dropped; count_o=5.
REQ-032 Run 20 cycles alternating enq 2'b11 / deq_take=1 and 2 across pointer wrap -> dequeued PC sequence strictly increasing by 4 with no gaps.
REQ-033 count=5, flush_i=1 with enq 2'b11 and deq_take=2 same cycle -> next cycle count_o=0, deq_valid0_o=0, deq_instr0_o=0x00000013.
REQ-034 count=1, deq_take=2 -> effective take 1, count_o=0. Separately, reset asserted mid-fill -> count_o=0 immediately without a clock edge.
